mem_trace_buf: RTL

Synthesizable, parametrised capture buffer for data-memory transactions in the MEM/WB region of the pipeline, replacing file-based logging with an on-chip trace. It records qualifying reads and writes with a cycle timestamp into a circular buffer. Address-range and per-op filters select what is recorded. Entries drain through a valid/ready port to a debug/UART block.

---
 rtl/core_pkg.sv | 7 +
 rtl/mem_trace_pkg.sv | 21 ++
 rtl/mem_trace_buf_if.sv | 12 +
 rtl/mem_trace_ring.sv | 66 ++++++
 rtl/mem_trace_buf.sv | 139 +++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Core-wide shared types. The trace buffer only needs the memory control bundle.
package core_pkg;

    // Bit 1 requests a load, bit 0 requests a store.
    typedef logic [1:0] mem_ctrl_t;

endpackage

// File: rtl/mem_trace_pkg.sv
// Shared types and default sizing for the data-memory trace buffer.
package mem_trace_pkg;

    localparam int DEF_DEPTH  = 64;
    localparam int DEF_TS_W   = 16;
    localparam int DEF_DROP_W = 8;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } trace_op_e;

    // Field order {op, ts, addr, data} is the layout the debug drain expects.
    typedef struct packed {
        trace_op_e           op;
        logic [DEF_TS_W-1:0] ts;
        logic [31:0]         addr;
        logic [31:0]         data;
    } trace_entry_t;

endpackage

// File: rtl/mem_trace_buf_if.sv
// Valid/ready drain port carrying trace entries from the buffer to a debug consumer.
interface mem_trace_buf_if;
    import mem_trace_pkg::*;

    logic         o_trValid;
    trace_entry_t o_trEntry;
    logic         i_trReady;

    modport master (output o_trValid, output o_trEntry, input i_trReady);
    modport slave  (input o_trValid, input o_trEntry, output i_trReady);

endinterface

// File: rtl/mem_trace_ring.sv
// Circular entry storage with two write slots per cycle, a first-word fall-through
// head, and an extra read-pointer advance used when the oldest entries are overwritten.
module mem_trace_ring
    import mem_trace_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic [1:0]    push_num,
    input  trace_entry_t  push_data0,
    input  trace_entry_t  push_data1,
    input  logic          pop,
    input  logic [1:0]    overwrite_num,
    output trace_entry_t  head,
    output logic [CW-1:0] count,
    output logic          valid
);

    trace_entry_t  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          valid_r;

    // Occupancy after this cycle's pushes, pop and overwritten entries.
    always_comb begin
        count_next_s = count_r + CW'(push_num) - CW'(pop) - CW'(overwrite_num);
    end

    // Storage write port: the first slot lands at wr_ptr, the second right behind it.
    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_clear) begin
            if (push_num != 2'd0) begin
                mem_r[wr_ptr_r] <= push_data0;
            end
            if (push_num == 2'd2) begin
                mem_r[wr_ptr_r + PW'(1'b1)] <= push_data1;
            end
        end
    end

    // Pointers, occupancy and the registered non-empty flag.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_r + PW'(push_num);
            rd_ptr_r <= rd_ptr_r + PW'(pop) + PW'(overwrite_num);
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != {CW{1'b0}});
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign valid = valid_r;

endmodule

// File: rtl/mem_trace_buf.sv
// On-chip trace of data-memory reads and writes: address/op filtering, timestamping,
// stop-on-full or overwrite-oldest policy, and saturating accounting of lost events.
module mem_trace_buf
    import mem_trace_pkg::*;
    import core_pkg::*;
#(
    parameter int  DEPTH  = DEF_DEPTH,
    parameter int  TS_W   = DEF_TS_W,
    parameter int  DROP_W = DEF_DROP_W,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               en_MEM,
    input  logic               en_WB,
    input  logic [31:0]        i_memAddr,
    input  logic [31:0]        i_writeData,
    input  mem_ctrl_t          i_ctrlMEM,
    input  logic [31:0]        i_readData,
    input  logic               i_logWrites,
    input  logic               i_logReads,
    input  logic [31:0]        i_addrLo,
    input  logic [31:0]        i_addrHi,
    input  logic               i_wrapMode,
    input  logic               i_clear,
    mem_trace_buf_if.master    tr,
    output logic [CW-1:0]      o_count,
    output logic               o_overflow,
    output logic [DROP_W-1:0]  o_dropCnt
);

    logic              in_range_s;
    logic              rd_ev_s;
    logic              wr_ev_s;
    logic              pop_s;
    logic              valid_s;
    logic [1:0]        ev_num_s;
    logic [1:0]        push_num_s;
    logic [1:0]        ovr_num_s;
    logic [1:0]        lost_num_s;
    logic [CW-1:0]     count_s;
    logic [CW-1:0]     free_s;
    trace_entry_t      rd_entry_s;
    trace_entry_t      wr_entry_s;
    trace_entry_t      slot0_s;
    trace_entry_t      head_s;
    logic [TS_W-1:0]   ts_r;
    logic              ovf_r;
    logic [DROP_W-1:0] drop_r;

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [1:0]        b);
        logic [DROP_W:0] sum_s;
        sum_s = {1'b0, a} + (DROP_W + 1)'(b);
        if (sum_s[DROP_W]) begin
            sat_add = {DROP_W{1'b1}};
        end else begin
            sat_add = sum_s[DROP_W-1:0];
        end
    endfunction

    // Event qualification and entry assembly; the read is the older instruction so it takes slot 0.
    always_comb begin
        in_range_s = (i_memAddr >= i_addrLo) && (i_memAddr <= i_addrHi);
        rd_ev_s    = i_ctrlMEM[1] && en_WB && i_logReads && in_range_s;
        wr_ev_s    = i_ctrlMEM[0] && en_MEM && i_logWrites && in_range_s;
        ev_num_s   = {1'b0, rd_ev_s} + {1'b0, wr_ev_s};
        pop_s      = valid_s && tr.i_trReady;
        free_s     = CW'(DEPTH) - count_s + CW'(pop_s);
        rd_entry_s = '{op: READ,  ts: DEF_TS_W'(ts_r), addr: i_memAddr, data: i_readData};
        wr_entry_s = '{op: WRITE, ts: DEF_TS_W'(ts_r), addr: i_memAddr, data: i_writeData};
        if (rd_ev_s) begin
            slot0_s = rd_entry_s;
        end else begin
            slot0_s = wr_entry_s;
        end
    end

    // Full-buffer policy: stop mode trims the later events, wrap mode pushes the head forward.
    always_comb begin
        push_num_s = ev_num_s;
        ovr_num_s  = 2'd0;
        lost_num_s = 2'd0;
        if (CW'(ev_num_s) > free_s) begin
            if (i_wrapMode) begin
                ovr_num_s  = ev_num_s - free_s[1:0];
                lost_num_s = ev_num_s - free_s[1:0];
            end else begin
                push_num_s = free_s[1:0];
                lost_num_s = ev_num_s - free_s[1:0];
            end
        end else begin
            push_num_s = ev_num_s;
        end
    end

    // Free-running timestamp and lost-event accounting; clear leaves the timestamp alone.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ts_r   <= {TS_W{1'b0}};
            ovf_r  <= 1'b0;
            drop_r <= {DROP_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(1'b1);
            if (i_clear) begin
                ovf_r  <= 1'b0;
                drop_r <= {DROP_W{1'b0}};
            end else begin
                drop_r <= sat_add(drop_r, lost_num_s);
                if (lost_num_s != 2'd0) begin
                    ovf_r <= 1'b1;
                end
            end
        end
    end

    mem_trace_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_clear       (i_clear),
        .push_num      (push_num_s),
        .push_data0    (slot0_s),
        .push_data1    (wr_entry_s),
        .pop           (pop_s),
        .overwrite_num (ovr_num_s),
        .head          (head_s),
        .count         (count_s),
        .valid         (valid_s)
    );

    assign tr.o_trValid = valid_s;
    assign tr.o_trEntry = head_s;
    assign o_count      = count_s;
    assign o_overflow   = ovf_r;
    assign o_dropCnt    = drop_r;

endmodule
